// File: rtl/bram_stream_reader.sv
// Reads data_num words from a data BRAM and streams them out as AXI4-Stream, using a credit-limited FIFO.
// Define BRAM_RD_LAT2_EN for a 2-cycle BRAM read latency (output register); default is 1 cycle.
module bram_stream_reader #(
  parameter int pADDR_WIDTH  = 12,
  parameter int pDATA_WIDTH  = 32,
  parameter int MAX_DATA_NUM = 1024,
  localparam int CNT_W = $clog2(MAX_DATA_NUM + 1)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   in_ap_start,
  input  logic [CNT_W-1:0]       data_num,
  output logic                   out_ap_idle,
  output logic                   out_ap_done,
  output logic [pADDR_WIDTH-1:0] out_A_data,
  output logic                   out_EN_data,
  input  logic [pDATA_WIDTH-1:0] in_Do_data,
  output logic [pDATA_WIDTH-1:0] out_m_tdata,
  output logic                   out_m_tvalid,
  output logic                   out_m_tlast,
  input  logic                   in_m_tready
);

`ifdef BRAM_RD_LAT2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = LAT + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int BYTES = pDATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]       r_n, r_k, w_n_clamp;
  logic [pADDR_WIDTH-1:0] r_addr;
  logic [LAT-1:0]         r_vld_pipe, r_last_pipe;
  logic [pDATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]       r_mem_last;
  logic [PTR_W-1:0]       r_wptr, r_rptr;
  logic [OCC_W-1:0]       r_occ;
  logic [OCC_W:0]         w_inflight, w_credit;
  logic                   w_issue, w_pop, w_wr, w_empty, w_head_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_n_clamp   = (data_num > CNT_W'(MAX_DATA_NUM)) ? CNT_W'(MAX_DATA_NUM) : data_num;
  assign w_empty     = (r_occ == '0);
  assign w_pop       = !w_empty && in_m_tready;
  assign w_wr        = r_vld_pipe[LAT-1];
  assign w_head_last = r_mem_last[r_rptr];

  // Reads in flight plus words buffered must never exceed the FIFO depth.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LAT; i++) w_inflight = w_inflight + (OCC_W+1)'(r_vld_pipe[i]);
  end
  assign w_credit = w_inflight + {1'b0, r_occ} - (OCC_W+1)'(w_pop);
  assign w_issue  = (r_state == S_RUN) && (r_k < r_n) && (w_credit < (OCC_W+1)'(DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    out_ap_idle = 1'b0;
    out_ap_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        out_ap_idle = 1'b1;
        if (in_ap_start) w_state_nxt = (w_n_clamp == '0) ? S_DONE : S_RUN;
      end
      S_RUN:  if (w_pop && w_head_last) w_state_nxt = S_DONE;
      S_DONE: begin
        out_ap_done = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_n         <= '0;
      r_k         <= '0;
      r_addr      <= '0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else begin
      if (r_state == S_IDLE && in_ap_start) begin
        r_n    <= w_n_clamp;
        r_k    <= '0;
        r_addr <= '0;
      end else if (w_issue) begin
        r_k    <= r_k + 1'b1;
        r_addr <= r_addr + pADDR_WIDTH'(BYTES);
      end
      r_vld_pipe[0]  <= w_issue;
      r_last_pipe[0] <= w_issue && (r_k == r_n - 1'b1);
      for (int i = 1; i < LAT; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_last_pipe[i] <= r_last_pipe[i-1];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_wr)  r_wptr <= ptr_inc(r_wptr);
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      r_occ <= r_occ + OCC_W'(w_wr) - OCC_W'(w_pop);
    end
  end

  // Storage needs no reset: occupancy gates every use of it.
  always_ff @(posedge aclk) begin
    if (w_wr) begin
      r_mem[r_wptr]      <= in_Do_data;
      r_mem_last[r_wptr] <= r_last_pipe[LAT-1];
    end
  end

  assign out_EN_data  = w_issue;
  assign out_A_data   = w_issue ? r_addr : '0;
  assign out_m_tvalid = !w_empty;
  assign out_m_tdata  = w_empty ? '0 : r_mem[r_rptr];
  assign out_m_tlast  = !w_empty && w_head_last;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized bench for bram_stream_reader: BRAM model, per-cycle reference checks, directed scenarios.
module tb_bram_stream_reader;
`ifdef BRAM_RD_LAT2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int P_IDLE = 0, P_RUN = 1, P_DONE = 2;

  logic        aclk = 1'b0;
  logic        aresetn, in_ap_start, out_ap_idle, out_ap_done, out_EN_data;
  logic [10:0] data_num;
  logic [11:0] out_A_data;
  logic [31:0] in_Do_data, out_m_tdata;
  logic        out_m_tvalid, out_m_tlast, in_m_tready;

  bram_stream_reader dut (
    .aclk(aclk), .aresetn(aresetn), .in_ap_start(in_ap_start), .data_num(data_num),
    .out_ap_idle(out_ap_idle), .out_ap_done(out_ap_done), .out_A_data(out_A_data),
    .out_EN_data(out_EN_data), .in_Do_data(in_Do_data), .out_m_tdata(out_m_tdata),
    .out_m_tvalid(out_m_tvalid), .out_m_tlast(out_m_tlast), .in_m_tready(in_m_tready)
  );

  always #5 aclk = ~aclk;

  // BRAM model: registered read data delivered LAT cycles after the enable cycle.
  logic [31:0] mem [0:1023];
  logic [31:0] b1d, b2d;
  always @(posedge aclk) begin
    b1d <= out_EN_data ? mem[out_A_data[11:2]] : 32'hDEAD_BEEF;
    b2d <= b1d;
  end
  assign in_Do_data = (LAT == 1) ? b1d : b2d;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Ready driver: 0 = high, 1 = toggle, 2 = random percent, 3 = held low.
  int rdy_mode = 0, rdy_pct = 100;
  initial begin
    in_m_tready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (rdy_mode)
        0: in_m_tready = 1'b1;
        1: in_m_tready = ~in_m_tready;
        2: in_m_tready = ($urandom_range(0, 99) < rdy_pct);
        default: in_m_tready = 1'b0;
      endcase
    end
  end

  // Reference model: tracks phase, reads issued and beats taken; checks every cycle.
  int m_phase = P_IDLE, m_n = 0, iss = 0, bts = 0, cyc = 0, start_cyc = 0;
  int n_done = 0, m_starts = 0, first_pending = 0, nobubble = 0;
  logic [11:0] last_addr;
  logic [31:0] cap [0:1023];
  logic pv = 0, pr = 0, pl = 0;
  logic [31:0] pd = 0;
  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        chk("rst_idle", out_ap_idle, 1);
        chk("rst_done", out_ap_done, 0);
        chk("rst_en", out_EN_data, 0);
        chk("rst_addr", out_A_data, 0);
        chk("rst_valid", out_m_tvalid, 0);
        chk("rst_last", out_m_tlast, 0);
        chk("rst_tdata", out_m_tdata, 0);
        m_phase = P_IDLE; iss = 0; bts = 0; pv = 0; first_pending = 0;
      end else begin
        automatic int  pop = (out_m_tvalid && in_m_tready) ? 1 : 0;
        automatic logic exp_en = (m_phase == P_RUN) && (iss < m_n) && (iss - bts - pop < LAT + 1);
        chk("idle", out_ap_idle, m_phase == P_IDLE);
        chk("done", out_ap_done, m_phase == P_DONE);
        if (out_ap_done) n_done++;
        chk("read_en", out_EN_data, exp_en);
        chk("read_addr", out_A_data, out_EN_data ? 12'(iss * 4) : 12'h0);
        if (out_EN_data) begin last_addr = out_A_data; iss++; end
        if (out_m_tvalid) chk("valid_phase", (m_phase == P_RUN) && (bts < m_n), 1);
        if (out_m_tvalid && first_pending != 0) begin
          chk("first_valid_lat", cyc - start_cyc, LAT + 2);
          first_pending = 0;
        end
        if (pv && !pr) begin
          chk("stall_valid", out_m_tvalid, 1);
          chk("stall_tdata", out_m_tdata, pd);
          chk("stall_tlast", out_m_tlast, pl);
        end
        if (nobubble != 0 && m_phase == P_RUN && bts > 0 && bts < m_n)
          chk("bubble", out_m_tvalid, 1);
        if (pop != 0) begin
          chk("beat_data", out_m_tdata, mem[bts]);
          chk("beat_last", out_m_tlast, bts == m_n - 1);
          cap[bts] = out_m_tdata;
          bts++;
        end
        pv = out_m_tvalid; pr = in_m_tready; pd = out_m_tdata; pl = out_m_tlast;
        case (m_phase)
          P_IDLE: if (in_ap_start) begin
            m_n = (data_num > 11'd1024) ? 1024 : int'(data_num);
            iss = 0; bts = 0; start_cyc = cyc; m_starts++;
            first_pending = (m_n > 0) ? 1 : 0;
            m_phase = (m_n == 0) ? P_DONE : P_RUN;
          end
          P_RUN: if (pop != 0 && bts == m_n) m_phase = P_DONE;
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  task automatic wait_done(input int maxc);
    int c = 0;
    int d0 = n_done;
    while (n_done == d0 && c < maxc) begin @(posedge aclk); c++; end
    chk("done_timeout", n_done != d0, 1);
  endtask

  task automatic do_xfer(input int n);
    @(posedge aclk); #1;
    data_num = 11'(n); in_ap_start = 1'b1;
    @(posedge aclk); #1;
    in_ap_start = 1'b0;
    wait_done(3000);
  endtask

  task automatic fill(input logic [31:0] base, input int rnd);
    for (int i = 0; i < 1024; i++) mem[i] = (rnd != 0) ? $urandom : base + 32'(i);
  endtask

  initial begin
    int d0, s0, c;
    aresetn = 1'b0; in_ap_start = 1'b0; data_num = '0;
    fill(32'h100, 0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // Ready always high: 8 words back to back.
    nobubble = 1; d0 = n_done;
    do_xfer(8);
    repeat (3) @(posedge aclk);
    chk("t1_beats", bts, 8);
    chk("t1_first", cap[0], 32'h100);
    chk("t1_last", cap[7], 32'h107);
    chk("t1_addr", last_addr, 12'h01C);
    chk("t1_done_once", n_done - d0, 1);
    nobubble = 0;

    // Toggling ready with a 10-cycle low burst.
    fill(32'h2000, 0);
    rdy_mode = 1;
    @(posedge aclk); #1;
    data_num = 11'd16; in_ap_start = 1'b1;
    @(posedge aclk); #1;
    in_ap_start = 1'b0;
    repeat (11) @(posedge aclk);
    #1 rdy_mode = 3;
    repeat (10) @(posedge aclk);
    #1 rdy_mode = 1;
    wait_done(500);
    chk("t2_beats", bts, 16);
    chk("t2_last", cap[15], 32'h200F);
    rdy_mode = 0;

    // Zero and one word.
    do_xfer(0);
    chk("t3_beats", bts, 0);
    do_xfer(1);
    chk("t4_beats", bts, 1);
    chk("t4_data", cap[0], 32'h2000);

    // Reset after 5 beats of a 20-word transfer.
    fill(32'h5000, 0);
    @(posedge aclk); #1;
    data_num = 11'd20; in_ap_start = 1'b1;
    @(posedge aclk); #1;
    in_ap_start = 1'b0;
    c = 0;
    while (bts < 5 && c < 200) begin @(posedge aclk); c++; end
    chk("t5_reach", bts >= 5, 1);
    #1 aresetn = 1'b0;
    #1;
    chk("t5_rst_valid", out_m_tvalid, 0);
    chk("t5_rst_idle", out_ap_idle, 1);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    do_xfer(4);
    chk("t5_beats", bts, 4);
    chk("t5_word3", cap[3], 32'h5003);

    // Start held high: one transfer per IDLE visit.
    s0 = m_starts; d0 = n_done;
    @(posedge aclk); #1;
    data_num = 11'd4; in_ap_start = 1'b1;
    repeat (30) @(posedge aclk);
    #1 in_ap_start = 1'b0;
    repeat (20) @(posedge aclk);
    chk("t6_starts", m_starts - s0, 4);
    chk("t6_dones", n_done - d0, 4);

    // Randomized counts and backpressure.
    for (int t = 0; t < 12; t++) begin
      automatic int n = $urandom_range(0, 40);
      fill(0, 1);
      rdy_pct = $urandom_range(30, 100);
      rdy_mode = 2;
      do_xfer(n);
      chk("rand_beats", bts, n);
    end

    // Oversized count clamps to the maximum.
    rdy_mode = 0; nobubble = 1;
    fill(32'h10000, 0);
    do_xfer(1100);
    chk("clamp_beats", bts, 1024);
    chk("clamp_last", cap[1023], 32'h103FF);
    nobubble = 0;

    repeat (3) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
